// File: rtl/i2s_modport_if.sv
// Bus bundle for the dual-link I2S block: data words, both serial links and
// the four event pulses. The block itself uses the master view; anything that
// drives data in and watches the links uses the slave view.
interface i2s_modport_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] txm_dat_i;
  logic [WORD_W-1:0] txs_dat_i;
  logic [WORD_W-1:0] rxs_dat_o;
  logic [WORD_W-1:0] rxm_dat_o;
  logic              i2s_sck1;
  logic              i2s_ws1;
  logic              i2s_sd1;
  logic              i2s_sck2;
  logic              i2s_ws2;
  logic              i2s_sd2;
  logic              txm_int_o;
  logic              txs_int_o;
  logic              rxm_int_o;
  logic              rxs_int_o;

  modport master (
    input  txm_dat_i, txs_dat_i,
    output rxs_dat_o, rxm_dat_o,
    output i2s_sck1, i2s_ws1, i2s_sd1,
    output i2s_sck2, i2s_ws2, i2s_sd2,
    output txm_int_o, txs_int_o, rxm_int_o, rxs_int_o
  );

  modport slave (
    output txm_dat_i, txs_dat_i,
    input  rxs_dat_o, rxm_dat_o,
    input  i2s_sck1, i2s_ws1, i2s_sd1,
    input  i2s_sck2, i2s_ws2, i2s_sd2,
    input  txm_int_o, txs_int_o, rxm_int_o, rxs_int_o
  );
endinterface

// File: rtl/i2s_modport.sv
// Dual-link I2S transceiver on the Wishbone clock.
// Link 1: TX master drives sck1/ws1/sd1, an internal RX slave receives it.
// Link 2: RX master drives sck2/ws2 and receives sd2 from an internal TX
// slave that recovers its timing from the registered sck2/ws2 lines.
module i2s_modport #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  i2s_modport_if.master bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(WORD_W / 2);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  typedef enum logic {SL_WAIT, SL_ARMED} slv_state_t;

  // Index 0 = link-1 TX master timing, index 1 = link-2 RX master timing.
  logic [DIV_W-1:0]  div_cnt  [2];
  logic [SLOT_W-1:0] slot     [2];
  logic [SLOT_W-1:0] slot_nxt [2];
  logic [1:0]        sck, ws, sck_fall, sck_rise;

  // Edge strobes: the clock on which a master's sck is about to toggle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sck_fall[i] = (div_cnt[i] == DIV_LAST) & sck[i];
      sck_rise[i] = (div_cnt[i] == DIV_LAST) & ~sck[i];
      slot_nxt[i] = (slot[i] == SLOT_LAST) ? '0 : slot[i] + SLOT_ONE;
    end
  end

  // Divider, sck toggle and slot/ws advance for both masters.
  // NOTE: every clocked register uses <= so all flops see pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 2; i++) begin
        div_cnt[i] <= '0;
        slot[i]    <= '0;
      end
      sck <= '0;
      ws  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (div_cnt[i] == DIV_LAST) begin
          div_cnt[i] <= '0;
          sck[i]     <= ~sck[i];
        end else begin
          div_cnt[i] <= div_cnt[i] + DIV_ONE;
        end
        if (sck_fall[i]) begin
          slot[i] <= slot_nxt[i];
          ws[i]   <= (slot_nxt[i] >= SLOT_HALF);
        end
      end
    end
  end

  // ---------------- Link-1 TX master ----------------
  logic [WORD_W-1:0] txm_sh;
  logic              sd1, txm_int;

  // Load at slot 1 (MSB out), otherwise shift one bit per sck fall.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      txm_sh  <= '0;
      sd1     <= 1'b0;
      txm_int <= 1'b0;
    end else begin
      txm_int <= 1'b0;
      if (sck_fall[0]) begin
        if (slot_nxt[0] == SLOT_ONE) begin
          txm_sh  <= {bus.txm_dat_i[WORD_W-2:0], 1'b0};
          sd1     <= bus.txm_dat_i[WORD_W-1];
          txm_int <= 1'b1;
        end else begin
          sd1    <= txm_sh[WORD_W-1];
          txm_sh <= {txm_sh[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------- Link-2 TX slave ----------------
  logic              sck2_q, ws2_q, sck2_fall_d, ws2_fall_d;
  logic [WORD_W-1:0] txs_sh;
  logic              sd2, txs_int, slv_load;
  slv_state_t        slv_state, slv_state_nxt;

  assign sck2_fall_d = sck2_q & ~sck[1];
  assign ws2_fall_d  = ws2_q & ~ws[1];

  // Slave state register: armed by a ws2 fall, disarmed by the load.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) slv_state <= SL_WAIT;
    else          slv_state <= slv_state_nxt;
  end

  // Arm on ws2 fall (slot 0); load on the following sck2 fall (slot 1).
  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    slv_state_nxt = slv_state;
    slv_load      = 1'b0;
    if (ws2_fall_d) begin
      slv_state_nxt = SL_ARMED;
    end else if ((slv_state == SL_ARMED) && sck2_fall_d) begin
      slv_state_nxt = SL_WAIT;
      slv_load      = 1'b1;
    end
  end

  // Edge-detect registers and slave serializer, one clock behind the master.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck2_q  <= 1'b0;
      ws2_q   <= 1'b0;
      txs_sh  <= '0;
      sd2     <= 1'b0;
      txs_int <= 1'b0;
    end else begin
      sck2_q  <= sck[1];
      ws2_q   <= ws[1];
      txs_int <= 1'b0;
      if (slv_load) begin
        txs_sh  <= {bus.txs_dat_i[WORD_W-2:0], 1'b0};
        sd2     <= bus.txs_dat_i[WORD_W-1];
        txs_int <= 1'b1;
      end else if (sck2_fall_d) begin
        sd2    <= txs_sh[WORD_W-1];
        txs_sh <= {txs_sh[WORD_W-2:0], 1'b0};
      end
    end
  end

  // ---------------- Receivers (0 = link-1 slave, 1 = link-2 master) -------
  logic [WORD_W-1:0] rx_sh  [2];
  logic [WORD_W-1:0] rx_dat [2];
  logic [1:0]        rx_ws_q, rx_int, rx_sd;

  assign rx_sd = {sd2, sd1};

  // Sample sd/ws on sck rise; a 1->0 ws step marks the LSB and ends the word.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 2; i++) begin
        rx_sh[i]  <= '0;
        rx_dat[i] <= '0;
      end
      rx_ws_q <= '0;
      rx_int  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rx_int[i] <= 1'b0;
        if (sck_rise[i]) begin
          rx_sh[i]   <= {rx_sh[i][WORD_W-2:0], rx_sd[i]};
          rx_ws_q[i] <= ws[i];
          if (rx_ws_q[i] && !ws[i]) begin
            rx_dat[i] <= {rx_sh[i][WORD_W-2:0], rx_sd[i]};
            rx_int[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.i2s_sck1  = sck[0];
  assign bus.i2s_ws1   = ws[0];
  assign bus.i2s_sd1   = sd1;
  assign bus.i2s_sck2  = sck[1];
  assign bus.i2s_ws2   = ws[1];
  assign bus.i2s_sd2   = sd2;
  assign bus.txm_int_o = txm_int;
  assign bus.txs_int_o = txs_int;
  assign bus.rxs_int_o = rx_int[0];
  assign bus.rxm_int_o = rx_int[1];
  assign bus.rxs_dat_o = rx_dat[0];
  assign bus.rxm_dat_o = rx_dat[1];

endmodule

// File: tb/tb_i2s_modport.sv
// Bench for i2s_modport. dut4 (CLK_DIV=4) is checked every clock against an
// arithmetic model driven by the clock count since reset release; dut3
// (CLK_DIV=3) is checked on link 2 with a word scoreboard.
`timescale 1ns/1ps
module tb_i2s_modport;
  localparam int CD = 4;
  localparam int W  = 32;
  localparam int P  = 2 * CD * W;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  i2s_modport_if #(.WORD_W(W)) bus4 ();
  i2s_modport_if #(.WORD_W(W)) bus3 ();

  i2s_modport #(.CLK_DIV(CD), .WORD_W(W)) dut4 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus4.master)
  );

  i2s_modport #(.CLK_DIV(3), .WORD_W(W)) dut3 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus3.master)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- Reference model for dut4 ----------------
  int          t = 0;
  logic [31:0] w1 = '0, w2 = '0, er1 = '0, er2 = '0;

  // Expected bus state after the t-th rising clock since reset release.
  always @(posedge wb_clk_i) begin
    int slot1, slot2, u;
    logic ev;
    #1;
    if (wb_rst_i) begin
      t = 0; w1 = '0; w2 = '0; er1 = '0; er2 = '0;
    end else begin
      t++;
      u     = t - 1;
      slot1 = (t / (2 * CD)) % W;
      slot2 = (u / (2 * CD)) % W;
      if (t % P == 2 * CD) w1 = bus4.txm_dat_i;
      if (u >= P && u % P == 2 * CD) w2 = bus4.txs_dat_i;
      ev = (t >= P) && (t % P == CD);
      if (ev) begin er1 = w1; er2 = w2; end
      check("sck1",    bus4.i2s_sck1, 32'((t / CD) % 2));
      check("ws1",     bus4.i2s_ws1,  32'(slot1 >= W / 2));
      check("sd1",     bus4.i2s_sd1,  32'((slot1 == 0) ? w1[0] : w1[W - slot1]));
      check("txm_int", bus4.txm_int_o, 32'(t % P == 2 * CD));
      check("rxs_int", bus4.rxs_int_o, 32'(ev));
      check("rxs_dat", bus4.rxs_dat_o, er1);
      check("sck2",    bus4.i2s_sck2, 32'((t / CD) % 2));
      check("ws2",     bus4.i2s_ws2,  32'(slot1 >= W / 2));
      check("sd2",     bus4.i2s_sd2,  32'((slot2 == 0) ? w2[0] : w2[W - slot2]));
      check("txs_int", bus4.txs_int_o, 32'(u >= P && u % P == 2 * CD));
      check("rxm_int", bus4.rxm_int_o, 32'(ev));
      check("rxm_dat", bus4.rxm_dat_o, er2);
    end
  end

  // ---------------- Scoreboard for dut3 link 2 ----------------
  logic [31:0] q3[$];
  int          n_rxm3 = 0;

  // Words loaded by the TX slave must come out of the RX master in order.
  always @(posedge wb_clk_i) begin
    logic [31:0] exp3;
    #1;
    if (wb_rst_i) begin
      q3.delete();
      q3.push_back(32'h0);
    end else begin
      if (bus3.txs_int_o) q3.push_back(bus3.txs_dat_i);
      if (bus3.rxm_int_o) begin
        n_rxm3++;
        check("rxm3_queue_nonempty", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
          exp3 = q3.pop_front();
          check("rxm3_dat", bus3.rxm_dat_o, exp3);
        end
      end
    end
  end

  task automatic wait_txm_int();
    int n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!bus4.txm_int_o && n < 2 * P);
    check("txm_int_seen", bus4.txm_int_o, 1'b1);
  endtask

  logic [31:0] pats [5] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h0000_0000, 32'hAAAA_5555};

  // Stimulus sequence.
  initial begin
    int n;
    bus4.txm_dat_i = 32'hA5A5_1234;
    bus4.txs_dat_i = 32'hDEAD_BEEF;
    bus3.txm_dat_i = 32'hA5A5_1234;
    bus3.txs_dat_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Held words for three frames.
    repeat (3 * P) @(negedge wb_clk_i);

    // Back-to-back words and fixed patterns, changed after each load.
    foreach (pats[i]) begin
      wait_txm_int();
      @(negedge wb_clk_i);
      bus4.txm_dat_i = pats[i];
      bus4.txs_dat_i = ~pats[i];
      bus3.txs_dat_i = pats[i];
    end
    repeat (P + 20) @(negedge wb_clk_i);

    // Inputs change every clock; only the load clock matters.
    repeat (4 * P) begin
      @(negedge wb_clk_i);
      bus4.txm_dat_i = $urandom;
      bus4.txs_dat_i = $urandom;
      bus3.txs_dat_i = $urandom;
    end

    // Asynchronous reset in mid-frame, between clock edges.
    bus4.txm_dat_i = 32'h1357_9BDF;
    bus4.txs_dat_i = 32'h0246_8ACE;
    bus3.txs_dat_i = 32'hC0FF_EE11;
    repeat (37) @(posedge wb_clk_i);
    #3 wb_rst_i = 1'b1;
    #1;
    check("rst_sck1", bus4.i2s_sck1, 1'b0);
    check("rst_ws1",  bus4.i2s_ws1,  1'b0);
    check("rst_sd1",  bus4.i2s_sd1,  1'b0);
    check("rst_sck2", bus4.i2s_sck2, 1'b0);
    check("rst_ws2",  bus4.i2s_ws2,  1'b0);
    check("rst_sd2",  bus4.i2s_sd2,  1'b0);
    check("rst_ints", {bus4.txm_int_o, bus4.txs_int_o, bus4.rxm_int_o, bus4.rxs_int_o}, 4'b0);
    check("rst_rxs_dat", bus4.rxs_dat_o, 32'h0);
    check("rst_rxm_dat", bus4.rxm_dat_o, 32'h0);
    check("rst_rxm3_dat", bus3.rxm_dat_o, 32'h0);
    repeat (2) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b0;

    n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!bus4.txm_int_o && n < 2 * P);
    check("first_txm_int_clock", n, 8);

    repeat (3 * P) begin
      @(negedge wb_clk_i);
      bus4.txm_dat_i = $urandom;
      bus4.txs_dat_i = $urandom;
      bus3.txs_dat_i = $urandom;
    end
    repeat (P) @(negedge wb_clk_i);

    check("rxm3_event_count_ok", 32'(n_rxm3 >= 10), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_modport.md
Name: i2s_modport

Overview:
- Self-contained dual-link I2S transceiver block, clocked from the Wishbone clock.
- Link 1: TX master generates i2s_sck1/i2s_ws1 and serializes txm_dat_i onto i2s_sd1. An internal RX slave deserializes the link into rxs_dat_o.
- Link 2: RX master generates i2s_sck2/i2s_ws2. An internal TX slave serializes txs_dat_i onto i2s_sd2, and the RX master deserializes it into rxm_dat_o.
- All bus lines are brought out as outputs for observation. One-cycle interrupt pulses flag word load (TX) and word completion (RX).

Parameters:
- CLK_DIV, 4, wb_clk_i cycles per SCK half-period (min 1); SCK period = 2*CLK_DIV clocks.
- WORD_W, 32, bits per frame; left = upper half, right = lower half; must be even.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  asynchronous active-high reset.
- txm_dat_i  in  32  word for link-1 TX master.
- txs_dat_i  in  32  word for link-2 TX slave.
- rxs_dat_o  out  32  last complete word received by the link-1 RX slave.
- rxm_dat_o  out  32  last complete word received by the link-2 RX master.
- i2s_sck1, i2s_ws1, i2s_sd1  out  1 each  link-1 bus, driven by the TX master.
- i2s_sck2, i2s_ws2  out  1 each  link-2 clock/word-select, driven by the RX master.
- i2s_sd2  out  1  link-2 data, driven by the TX slave.
- txm_int_o, txs_int_o, rxm_int_o, rxs_int_o  out  1 each  single-cycle event pulses.

Behaviour:
- Reset (async, any time including mid-frame):
  - All outputs are 0: sck, ws, sd, data words and interrupts.
  - Divider, slot counters and shift registers are cleared.
  - The frame restarts at slot 0 on release.
- Clock generation (each master):
  - div_cnt counts 0..CLK_DIV-1; sck toggles when div_cnt==CLK_DIV-1, then div_cnt wraps.
  - The first rising sck edge occurs at clock CLK_DIV after reset release; the first falling edge at 2*CLK_DIV.
- Slots:
  - A slot counter 0..WORD_W-1 advances on each sck falling edge and wraps.
  - ws = 1 for slots WORD_W/2..WORD_W-1, else 0; ws changes only with sck falling.
  - Frame length = WORD_W*2*CLK_DIV clocks (256 at defaults).
- Transmitter (TX master on link 1, TX slave on link 2):
  - sd changes only on the sck falling edge, using standard I2S one-bit delay.
  - Slot 1 carries the MSB (bit WORD_W-1); slot k carries bit WORD_W-k; slot 0 carries the LSB of the previous word.
  - On entering slot 1, the shift register loads the data input and the TX interrupt pulses high for exactly one clock.
  - The data input needs to be stable only on that clock.
  - In the first frame after reset, slot 0 drives 0.
- TX slave timing:
  - Derives slot timing from i2s_sck2/i2s_ws2 (registered edge detection on wb_clk_i), not from its own divider.
  - A ws2 falling edge marks slot 0; the slave loads on the next sck2 falling edge.
  - Its sd2 may lag the master's sck2 falling edge by at most 2 clocks, so CLK_DIV >= 3 is required for link 2.
- Receiver (RX slave on link 1, RX master on link 2):
  - Samples sd and ws on each sck rising edge and shifts sd into a WORD_W register, MSB first.
  - When sampled ws is 0 and the previously sampled ws was 1 (slot 0, the LSB), rx_dat_o <= {shreg[WORD_W-2:0], sd} and the RX interrupt pulses one clock, on the same clock rx_dat_o updates.
  - The first frame after reset produces no receive event.
- Latency: a word loaded at slot 1 of frame N appears at the receiver at slot 0 of frame N+1.
- Independence:
  - Links 1 and 2 are fully independent.
  - Simultaneous events on different links are all reported.
  - An interrupt never stretches beyond one clock.

Test Plan:
- CLK_DIV=4, txm_dat_i=32'hA5A5_1234 held:
  - sck1 period is 8 clocks and ws1 period is 256 clocks.
  - txm_int_o pulses once per frame.
  - rxs_dat_o=32'hA5A5_1234 with rxs_int_o pulsing one clock at the ws1 fall of the second frame.
- Link 2, txs_dat_i=32'hDEAD_BEEF:
  - txs_int_o pulses once per frame.
  - rxm_dat_o=32'hDEAD_BEEF and rxm_int_o pulses one frame later.
- Back-to-back words: change txm_dat_i 32'h0000_0001 -> 32'h8000_0000 after each txm_int_o -> rxs_dat_o follows the same sequence one frame later.
- Patterns 32'hFFFF_FFFF, 32'h0000_0000, 32'hAAAA_5555:
  - sd1 matches bits MSB-first starting at slot 1.
  - ws1 is low for 16 slots and high for 16 slots.
- Assert wb_rst_i mid-frame asynchronously (between clock edges):
  - All outputs go 0 immediately.
  - After release, the first txm_int_o occurs at clock 8.
  - No rx interrupt occurs in the first frame.
- CLK_DIV=3 on link 2: rxm_dat_o matches txs_dat_i, confirming sd2 lag stays within budget.
